// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
//   Shared Y86-64 definitions for the execute stage:
//     icode_e   - instruction codes
//     alu_fn_e  - ALU function codes (match OPq ifun 0..3)
//     cond_e    - jXX / cmovXX condition codes
//     cc_t      - condition-code register {zf, sf, of}
//     cond_eval - evaluates a condition code against a CC value
// -----------------------------------------------------------------------------
package y86_pkg;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,   // also cmovXX
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_XOR = 2'd3
   } alu_fn_e;

   typedef enum logic [3:0] {
      C_ALWAYS = 4'd0,
      C_LE     = 4'd1,
      C_L      = 4'd2,
      C_E      = 4'd3,
      C_NE     = 4'd4,
      C_GE     = 4'd5,
      C_G      = 4'd6
   } cond_e;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   // Stack pointer step for call/ret/push/pop.
   localparam logic [63:0] STACK_STEP = 64'd8;

   // Condition codes above C_G are undefined and evaluate to false.
   function automatic logic cond_eval(input logic [3:0] fn, input cc_t cc);
      logic lt;
      lt = cc.sf ^ cc.of;
      case (fn)
         C_ALWAYS: cond_eval = 1'b1;
         C_LE:     cond_eval = lt | cc.zf;
         C_L:      cond_eval = lt;
         C_E:      cond_eval = cc.zf;
         C_NE:     cond_eval = !cc.zf;
         C_GE:     cond_eval = !lt;
         C_G:      cond_eval = !lt && !cc.zf;
         default:  cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu64.sv
// -----------------------------------------------------------------------------
// alu64
//   Combinational 64-bit ALU, y = b op a (two's complement, wrap-around).
//   Ports:
//     a_i   [63:0] in  : operand A (subtrahend for ALU_SUB)
//     b_i   [63:0] in  : operand B
//     fn_i  alu_fn_e in: function select
//     y_o   [63:0] out : result
//     of_o         out : signed overflow (0 for and/xor)
// -----------------------------------------------------------------------------
module alu64
   import y86_pkg::*;
(
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  alu_fn_e     fn_i,
   output logic [63:0] y_o,
   output logic        of_o
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      y_o  = '0;
      of_o = 1'b0;
      case (fn_i)
         ALU_ADD: begin
            y_o  = b_i + a_i;
            // Same-signed operands producing a differently-signed sum.
            of_o = (a_i[63] == b_i[63]) && (y_o[63] != b_i[63]);
         end
         ALU_SUB: begin
            y_o  = b_i - a_i;
            // b - a overflows when the signs differ and the result leaves b's sign.
            of_o = (a_i[63] != b_i[63]) && (y_o[63] != b_i[63]);
         end
         ALU_AND: y_o = b_i & a_i;
         ALU_XOR: y_o = b_i ^ a_i;
         default: ;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Y86-64 execute stage with a single-entry registered output buffer.
//   Ports:
//     clk, rst               : rising-edge clock, async active-high reset
//     in_valid / in_ready    : decode-side handshake
//     icode, ifun [3:0]      : instruction and function/condition code
//     valA, valB, valC [63:0]: operands
//     out_valid / out_ready  : memory-side handshake
//     valE [63:0], cnd, err  : registered result, condition outcome, OPq error
//     zf, sf, of             : current condition-code register
// -----------------------------------------------------------------------------
module execute_stage
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [63:0] valA,
   input  logic [63:0] valB,
   input  logic [63:0] valC,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] valE,
   output logic        cnd,
   output logic        zf,
   output logic        sf,
   output logic        of,
   output logic        err
);

   logic        out_valid_q;
   logic [63:0] val_e_q, val_e_d;
   logic        cnd_q, cnd_d;
   logic        err_q, err_d;
   cc_t         cc_q, cc_d;

   logic [63:0] alu_a, alu_y;
   alu_fn_e     alu_fn;
   logic        alu_of;
   logic        accept;

   // The buffer frees up in the same cycle the consumer takes the result.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Operand B is always valB; only A and the function are steered.
   alu64 u_alu (
      .a_i  (alu_a),
      .b_i  (valB),
      .fn_i (alu_fn),
      .y_o  (alu_y),
      .of_o (alu_of)
   );

   always_comb begin
      alu_a   = valA;
      alu_fn  = ALU_ADD;
      val_e_d = '0;
      cnd_d   = 1'b0;
      err_d   = 1'b0;
      cc_d    = cc_q;
      case (icode_e'(icode))
         I_OPQ: begin
            if (ifun <= 4'd3) begin
               alu_fn  = alu_fn_e'(ifun[1:0]);
               val_e_d = alu_y;
               cc_d    = '{zf: (alu_y == '0), sf: alu_y[63], of: alu_of};
            end else begin
               err_d = 1'b1;
            end
         end
         // cnd reads cc_q, i.e. the flags as they stand before this edge.
         I_RRMOVQ: begin
            val_e_d = valA;
            cnd_d   = cond_eval(ifun, cc_q);
         end
         I_JXX:    cnd_d   = cond_eval(ifun, cc_q);
         I_IRMOVQ: val_e_d = valC;
         I_RMMOVQ, I_MRMOVQ: begin
            alu_a   = valC;
            val_e_d = alu_y;
         end
         I_CALL, I_PUSHQ: begin
            alu_a   = STACK_STEP;
            alu_fn  = ALU_SUB;
            val_e_d = alu_y;
         end
         I_RET, I_POPQ: begin
            alu_a   = STACK_STEP;
            val_e_d = alu_y;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         val_e_q     <= '0;
         cnd_q       <= 1'b0;
         err_q       <= 1'b0;
         cc_q        <= CC_RESET;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         val_e_q     <= val_e_d;
         cnd_q       <= cnd_d;
         err_q       <= err_d;
         cc_q        <= cc_d;
      end else if (out_ready) begin
         // Consumed with nothing new: drop valid, keep the payload as-is.
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign valE      = val_e_q;
   assign cnd       = cnd_q;
   assign err       = err_q;
   assign zf        = cc_q.zf;
   assign sf        = cc_q.sf;
   assign of        = cc_q.of;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  icode, ifun;
   logic [63:0] valA, valB, valC;
   logic        out_valid, out_ready;
   logic [63:0] valE;
   logic        cnd, zf, sf, of, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .icode     (icode),
      .ifun      (ifun),
      .valA      (valA),
      .valB      (valB),
      .valC      (valC),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .valE      (valE),
      .cnd       (cnd),
      .zf        (zf),
      .sf        (sf),
      .of        (of),
      .err       (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_cc(input string tag, input logic ezf, input logic esf, input logic eof);
      check({tag, ".zf"}, {63'd0, zf}, {63'd0, ezf});
      check({tag, ".sf"}, {63'd0, sf}, {63'd0, esf});
      check({tag, ".of"}, {63'd0, of}, {63'd0, eof});
   endtask

   // Called at #1 after a rising edge; presents one instruction for one edge
   // with the consumer ready, then returns #1 after that edge.
   task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      icode     = ic;
      ifun      = fn;
      valA      = a;
      valB      = b;
      valC      = c;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;

      // Reset state, before any clock edge.
      #3;
      check("rst.out_valid", {63'd0, out_valid}, 64'd0);
      check("rst.valE", valE, 64'd0);
      check("rst.cnd", {63'd0, cnd}, 64'd0);
      check("rst.err", {63'd0, err}, 64'd0);
      check_cc("rst", 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst.in_ready", {63'd0, in_ready}, 64'd1);

      // add overflow
      issue(4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
      check("add.out_valid", {63'd0, out_valid}, 64'd1);
      check("add.valE", valE, 64'h8000_0000_0000_0000);
      check_cc("add", 1'b0, 1'b1, 1'b1);

      // sub to zero, then back-to-back je sees the new ZF
      issue(4'h6, 4'd1, 64'd5, 64'd5, 64'd0);
      check("sub.valE", valE, 64'd0);
      check_cc("sub", 1'b1, 1'b0, 1'b0);
      issue(4'h7, 4'd3, 64'd0, 64'd0, 64'd0);
      check("je.cnd", {63'd0, cnd}, 64'd1);
      check("je.valE", valE, 64'd0);
      issue(4'h7, 4'd4, 64'd0, 64'd0, 64'd0);
      check("jne.cnd", {63'd0, cnd}, 64'd0);

      // and / xor
      issue(4'h6, 4'd2, 64'hF0, 64'hFF, 64'd0);
      check("and.valE", valE, 64'hF0);
      check_cc("and", 1'b0, 1'b0, 1'b0);
      issue(4'h6, 4'd3, 64'hAB, 64'hAB, 64'd0);
      check("xor.valE", valE, 64'd0);
      check_cc("xor", 1'b1, 1'b0, 1'b0);

      // sub overflow: 0x8000.. - 1
      issue(4'h6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
      check("subov.valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
      check_cc("subov", 1'b0, 1'b0, 1'b1);
      issue(4'h2, 4'd2, 64'h55, 64'h0, 64'd0);
      check("cmovl.cnd", {63'd0, cnd}, 64'd1);
      check("cmovl.valE", valE, 64'h55);
      issue(4'h2, 4'd6, 64'h66, 64'h0, 64'd0);
      check("cmovg.cnd", {63'd0, cnd}, 64'd0);

      // invalid OPq function
      issue(4'h6, 4'd7, 64'd3, 64'd4, 64'd0);
      check("badop.err", {63'd0, err}, 64'd1);
      check("badop.valE", valE, 64'd0);
      check_cc("badop", 1'b0, 1'b0, 1'b1);
      issue(4'h7, 4'd7, 64'd0, 64'd0, 64'd0);
      check("j7.cnd", {63'd0, cnd}, 64'd0);
      check("j7.err", {63'd0, err}, 64'd0);
      issue(4'h7, 4'd5, 64'd0, 64'd0, 64'd0);
      check("jge.cnd", {63'd0, cnd}, 64'd0);
      issue(4'h7, 4'd0, 64'd0, 64'd0, 64'd0);
      check("jmp.cnd", {63'd0, cnd}, 64'd1);

      // stack and address arithmetic
      issue(4'hA, 4'd0, 64'd0, 64'h100, 64'd0);
      check("push.valE", valE, 64'hF8);
      check("push.cnd", {63'd0, cnd}, 64'd0);
      issue(4'hB, 4'd0, 64'd0, 64'h100, 64'd0);
      check("pop.valE", valE, 64'h108);
      check_cc("stack", 1'b0, 1'b0, 1'b1);
      issue(4'h8, 4'd0, 64'd0, 64'h40, 64'd0);
      check("call.valE", valE, 64'h38);
      issue(4'h9, 4'd0, 64'd0, 64'h40, 64'd0);
      check("ret.valE", valE, 64'h48);
      issue(4'h4, 4'd0, 64'h9, 64'h10, 64'h20);
      check("rmmov.valE", valE, 64'h30);
      issue(4'h5, 4'd0, 64'h9, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF);
      check("mrmov.valE", valE, 64'hFFF);
      issue(4'h0, 4'd0, 64'h9, 64'h10, 64'h20);
      check("halt.valE", valE, 64'd0);

      // backpressure hold, then consume-and-accept in one cycle
      issue(4'h3, 4'd0, 64'd0, 64'd0, 64'h1234);
      check("irmov.valE", valE, 64'h1234);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      icode = 4'h3; valC = 64'h5678;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("hold.valE", valE, 64'h1234);
         check("hold.in_ready", {63'd0, in_ready}, 64'd0);
         check("hold.out_valid", {63'd0, out_valid}, 64'd1);
      end
      out_ready = 1'b1;
      #1;
      check("pulse.in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      check("pulse.valE", valE, 64'h5678);
      check("pulse.out_valid", {63'd0, out_valid}, 64'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("drain.out_valid", {63'd0, out_valid}, 64'd0);
      check("drain.valE", valE, 64'h5678);

      // async reset mid-hold with CC = {0,1,1}
      issue(4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("prerst.out_valid", {63'd0, out_valid}, 64'd1);
      check_cc("prerst", 1'b0, 1'b1, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("arst.out_valid", {63'd0, out_valid}, 64'd0);
      check("arst.valE", valE, 64'd0);
      check_cc("arst", 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("postrst.in_ready", {63'd0, in_ready}, 64'd1);
      check("postrst.out_valid", {63'd0, out_valid}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
